// File: rtl/diff_core_pkg.sv
// Shared constants, types and helpers for the FM/guard write-back path.
package diff_core_pkg;

  localparam int unsigned FM_WORD_BYTES           = 8;
  localparam int unsigned GUARD_WORD_NUM          = 8;
  localparam int unsigned FM_GUARD_MEM_ADDR_WIDTH = 12;

  localparam int unsigned FM_LANE_WIDTH    = 8;
  localparam int unsigned GUARD_LANE_WIDTH = 6;
  localparam int unsigned MEM_DATA_WIDTH   = 64;
  localparam int unsigned PACE_WIDTH       = 16;

  localparam int unsigned FM_WORD_WIDTH    = FM_LANE_WIDTH * FM_WORD_BYTES;
  localparam int unsigned GUARD_WORD_WIDTH = GUARD_LANE_WIDTH * GUARD_WORD_NUM;

  typedef enum logic [1:0] {
    PW_IDLE,
    PW_RUN,
    PW_DONE
  } pack_wr_state_e;

  // Guard words occupy the low bits of a memory word; the rest reads as zero.
  function automatic logic [MEM_DATA_WIDTH-1:0] guard_word_ext(
    input logic [GUARD_WORD_WIDTH-1:0] w
  );
    return MEM_DATA_WIDTH'(w);
  endfunction

endpackage

// File: rtl/fm_guard_pack_writer_if.sv
// Stream inputs, layer control and SRAM write port of the FM/guard pack writer.
interface fm_guard_pack_writer_if #(
  parameter int unsigned ADDR_WIDTH = diff_core_pkg::FM_GUARD_MEM_ADDR_WIDTH
);

  logic                                       start_i;
  logic [diff_core_pkg::PACE_WIDTH-1:0]       pace_i;
  logic [diff_core_pkg::PACE_WIDTH-1:0]       guard_pace_i;
  logic [ADDR_WIDTH-1:0]                      fm_base_i;
  logic [ADDR_WIDTH-1:0]                      guard_base_i;

  logic [diff_core_pkg::FM_LANE_WIDTH-1:0]    data_i;
  logic                                       data_i_valid;
  logic                                       fm_buf_ready;
  logic [diff_core_pkg::GUARD_LANE_WIDTH-1:0] guard_i;
  logic                                       guard_i_valid;
  logic                                       guard_buf_ready;

  logic                                       mem_wr_en;
  logic                                       mem_wr_sel;
  logic [ADDR_WIDTH-1:0]                      mem_wr_addr;
  logic [diff_core_pkg::MEM_DATA_WIDTH-1:0]   mem_wr_data;

  logic                                       busy_o;
  logic                                       done_o;

  modport slave (
    input  start_i, pace_i, guard_pace_i, fm_base_i, guard_base_i,
    input  data_i, data_i_valid, guard_i, guard_i_valid,
    output fm_buf_ready, guard_buf_ready,
    output mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
    output busy_o, done_o
  );

  modport master (
    output start_i, pace_i, guard_pace_i, fm_base_i, guard_base_i,
    output data_i, data_i_valid, guard_i, guard_i_valid,
    input  fm_buf_ready, guard_buf_ready,
    input  mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
    input  busy_o, done_o
  );

endinterface

// File: rtl/lane_packer.sv
// Packs a stream of LANE_WIDTH-bit entries into LANES-wide words and holds one
// completed word in a pending register until the write arbiter grants it.
module lane_packer
  import diff_core_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned LANES      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic [PACE_WIDTH-1:0]         count_i,
  input  logic                          run_i,
  input  logic [LANE_WIDTH-1:0]         data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          grant_i,
  output logic                          pend_v_o,
  output logic [LANE_WIDTH*LANES-1:0]   pend_word_o,
  output logic                          drained_o
);

  localparam int unsigned WordW    = LANE_WIDTH * LANES;
  localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LaneIdxW-1:0]   lane_q, lane_d;
  logic [WordW-1:0]      acc_q, acc_d;
  logic [WordW-1:0]      pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [PACE_WIDTH-1:0] left_q, left_d;
  logic                  last_lane;
  logic                  accept;

  assign last_lane = (lane_q == LaneIdxW'(LANES - 1)) || (left_q == PACE_WIDTH'(1));

  // A pending word being granted this cycle frees the slot for a completing word.
  assign ready_o = run_i && (left_q != '0) && !(pend_v_q && !grant_i && last_lane);
  assign accept  = valid_i && ready_o;

  always_comb begin
    lane_d   = lane_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    left_d   = left_q;

    if (grant_i) begin
      pend_v_d = 1'b0;
    end

    if (load_i) begin
      left_d = count_i;
      lane_d = '0;
      acc_d  = '0;
    end else if (accept) begin
      acc_d[int'(lane_q) * LANE_WIDTH +: LANE_WIDTH] = data_i;
      left_d = left_q - PACE_WIDTH'(1);
      if (last_lane) begin
        pend_d   = acc_d;
        pend_v_d = 1'b1;
        acc_d    = '0;
        lane_d   = '0;
      end else begin
        lane_d = lane_q + LaneIdxW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      lane_q   <= '0;
      acc_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      left_q   <= '0;
    end else begin
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      left_q   <= left_d;
    end
  end

  assign pend_v_o    = pend_v_q;
  assign pend_word_o = pend_q;
  assign drained_o   = (left_d == '0) && !pend_v_d;

endmodule

// File: rtl/fm_guard_pack_writer.sv
// Packs the FM byte stream and the guard stream into 64-bit words and writes
// both through one shared SRAM port, one layer per start pulse.
module fm_guard_pack_writer
  import diff_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FM_GUARD_MEM_ADDR_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  fm_guard_pack_writer_if.slave bus
);

  pack_wr_state_e state_q;
  logic           busy_q;
  logic           done_q;
  logic           rr_q;
  logic [ADDR_WIDTH-1:0] fm_addr_q;
  logic [ADDR_WIDTH-1:0] g_addr_q;

  logic                        load;
  logic                        run;
  logic                        fm_pend_v, g_pend_v;
  logic                        fm_grant, g_grant;
  logic                        fm_drained, g_drained;
  logic [FM_WORD_WIDTH-1:0]    fm_word;
  logic [GUARD_WORD_WIDTH-1:0] g_word;

  assign load = (state_q == PW_IDLE) && bus.start_i;
  assign run  = (state_q == PW_RUN);

  lane_packer #(
    .LANE_WIDTH (FM_LANE_WIDTH),
    .LANES      (FM_WORD_BYTES)
  ) u_fm_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .count_i     (bus.pace_i),
    .run_i       (run),
    .data_i      (bus.data_i),
    .valid_i     (bus.data_i_valid),
    .ready_o     (bus.fm_buf_ready),
    .grant_i     (fm_grant),
    .pend_v_o    (fm_pend_v),
    .pend_word_o (fm_word),
    .drained_o   (fm_drained)
  );

  lane_packer #(
    .LANE_WIDTH (GUARD_LANE_WIDTH),
    .LANES      (GUARD_WORD_NUM)
  ) u_guard_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .count_i     (bus.guard_pace_i),
    .run_i       (run),
    .data_i      (bus.guard_i),
    .valid_i     (bus.guard_i_valid),
    .ready_o     (bus.guard_buf_ready),
    .grant_i     (g_grant),
    .pend_v_o    (g_pend_v),
    .pend_word_o (g_word),
    .drained_o   (g_drained)
  );

  // rr_q == 0 favours FM when both pending registers hold a word.
  always_comb begin
    fm_grant = fm_pend_v && (!g_pend_v || !rr_q);
    g_grant  = g_pend_v && (!fm_pend_v || rr_q);
  end

  assign bus.mem_wr_en   = fm_grant || g_grant;
  assign bus.mem_wr_sel  = g_grant;
  assign bus.mem_wr_addr = fm_grant ? fm_addr_q : (g_grant ? g_addr_q : '0);
  assign bus.mem_wr_data = fm_grant ? MEM_DATA_WIDTH'(fm_word) :
                           (g_grant ? guard_word_ext(g_word) : '0);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= PW_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rr_q      <= 1'b0;
      fm_addr_q <= '0;
      g_addr_q  <= '0;
    end else begin
      if (fm_pend_v && g_pend_v) begin
        rr_q <= ~rr_q;
      end
      if (fm_grant) begin
        fm_addr_q <= fm_addr_q + ADDR_WIDTH'(1);
      end
      if (g_grant) begin
        g_addr_q <= g_addr_q + ADDR_WIDTH'(1);
      end

      unique case (state_q)
        PW_IDLE: begin
          if (bus.start_i) begin
            state_q   <= PW_RUN;
            busy_q    <= 1'b1;
            fm_addr_q <= bus.fm_base_i;
            g_addr_q  <= bus.guard_base_i;
          end
        end
        PW_RUN: begin
          if (fm_drained && g_drained) begin
            state_q <= PW_DONE;
            done_q  <= 1'b1;
          end
        end
        PW_DONE: begin
          state_q <= PW_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= PW_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_fm_guard_pack_writer.sv
// Directed bench for fm_guard_pack_writer with a write scoreboard per stream.
module tb_fm_guard_pack_writer;
  import diff_core_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_wr  = 0;
  int   fm_first = -1, fm_last = -1, g_first = -1, g_last = -1, last_wr = -1;

  wr_t        exp_fm[$];
  wr_t        exp_g[$];
  wr_t        mon_e;
  logic [7:0] fm_src[$];
  logic [5:0] g_src[$];

  fm_guard_pack_writer_if bus ();

  fm_guard_pack_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write is matched against the head of its stream's queue.
  initial forever begin
    @(negedge clk);
    if (bus.mem_wr_en === 1'b1) begin
      n_wr++;
      last_wr = cyc;
      if (bus.mem_wr_sel) begin
        if (g_first < 0) g_first = cyc;
        g_last = cyc;
        if (exp_g.size() == 0) check_int("guard_write_expected", exp_g.size(), 1);
        else begin
          mon_e = exp_g.pop_front();
          check("guard_addr", 64'(bus.mem_wr_addr), 64'(mon_e.addr));
          check("guard_data", bus.mem_wr_data, mon_e.data);
        end
      end else begin
        if (fm_first < 0) fm_first = cyc;
        fm_last = cyc;
        if (exp_fm.size() == 0) check_int("fm_write_expected", exp_fm.size(), 1);
        else begin
          mon_e = exp_fm.pop_front();
          check("fm_addr", 64'(bus.mem_wr_addr), 64'(mon_e.addr));
          check("fm_data", bus.mem_wr_data, mon_e.data);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.start_i       = 1'b0;
    bus.pace_i        = '0;
    bus.guard_pace_i  = '0;
    bus.fm_base_i     = '0;
    bus.guard_base_i  = '0;
    bus.data_i        = '0;
    bus.data_i_valid  = 1'b0;
    bus.guard_i       = '0;
    bus.guard_i_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_fm.delete();
    exp_g.delete();
  endtask

  task automatic push_expected(input logic [11:0] fb, input logic [11:0] gb);
    wr_t e;
    for (int w = 0; w * 8 < fm_src.size(); w++) begin
      e.data = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < fm_src.size()) e.data[8*k +: 8] = fm_src[w*8+k];
      e.addr = fb + 12'(w);
      exp_fm.push_back(e);
    end
    for (int w = 0; w * 8 < g_src.size(); w++) begin
      e.data = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < g_src.size()) e.data[6*k +: 6] = g_src[w*8+k];
      e.addr = gb + 12'(w);
      exp_g.push_back(e);
    end
  endtask

  task automatic run_layer(input logic [11:0] fb, input logic [11:0] gb, input bit poke,
                           output int r, output int done_cyc,
                           output int fm_stall, output int g_stall);
    int   fi, gi, n;
    logic fv, gv;
    push_expected(fb, gb);
    fm_first = -1; fm_last = -1; g_first = -1; g_last = -1;
    @(posedge clk); #1;
    bus.start_i      = 1'b1;
    bus.pace_i       = 16'(fm_src.size());
    bus.guard_pace_i = 16'(g_src.size());
    bus.fm_base_i    = fb;
    bus.guard_base_i = gb;
    @(posedge clk); #1;
    // Scramble the layer parameters to prove they were latched at start.
    bus.start_i      = 1'b0;
    bus.pace_i       = '1;
    bus.guard_pace_i = '1;
    bus.fm_base_i    = ~fb;
    bus.guard_base_i = ~gb;
    r = cyc; fi = 0; gi = 0; n = 0; done_cyc = -1; fm_stall = 0; g_stall = 0;
    while (done_cyc < 0 && n < 200) begin
      fv = (fi < fm_src.size());
      gv = (gi < g_src.size());
      bus.data_i_valid  = fv;
      bus.data_i        = fv ? fm_src[fi] : 8'h00;
      bus.guard_i_valid = gv;
      bus.guard_i       = gv ? g_src[gi] : 6'h00;
      bus.start_i       = poke && (n == 2);
      @(negedge clk);
      if (n == 0) check_int("busy_in_run", int'(bus.busy_o), 1);
      if (bus.done_o) done_cyc = cyc;
      if (fv) begin
        if (bus.fm_buf_ready) fi++;
        else fm_stall++;
      end
      if (gv) begin
        if (bus.guard_buf_ready) gi++;
        else g_stall++;
      end
      @(posedge clk); #1;
      n++;
    end
    clear_inputs();
    check_int("layer_done_seen", int'(done_cyc >= 0), 1);
    @(negedge clk);
    check_int("busy_after_done", int'(bus.busy_o), 0);
    check_int("done_single_pulse", int'(bus.done_o), 0);
    check_int("fm_words_outstanding", exp_fm.size(), 0);
    check_int("guard_words_outstanding", exp_g.size(), 0);
  endtask

  initial begin
    int r, dc, fs, gs, nw;

    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_int("rst_wr_en", int'(bus.mem_wr_en), 0);
    check_int("rst_wr_sel", int'(bus.mem_wr_sel), 0);
    check("rst_wr_addr", 64'(bus.mem_wr_addr), 64'h0);
    check("rst_wr_data", bus.mem_wr_data, 64'h0);
    check_int("rst_busy", int'(bus.busy_o), 0);
    check_int("rst_done", int'(bus.done_o), 0);
    check_int("rst_fm_ready", int'(bus.fm_buf_ready), 0);
    check_int("rst_guard_ready", int'(bus.guard_buf_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Two FM words and one guard word streamed back to back.
    do_reset();
    fm_src.delete(); g_src.delete();
    for (int i = 0; i < 16; i++) fm_src.push_back(8'(i));
    for (int i = 0; i < 8; i++) g_src.push_back(6'(i));
    run_layer(12'h010, 12'h200, 1'b0, r, dc, fs, gs);
    check_int("t1_fm_first_cycle", fm_first, r + 8);
    check_int("t1_guard_cycle", g_first, r + 9);
    check_int("t1_done_cycle", dc, r + 17);
    check_int("t1_done_after_last_wr", dc, last_wr + 1);
    check_int("t1_fm_stalls", fs, 0);
    check_int("t1_guard_stalls", gs, 0);

    // Partial final word, no guards, plus an ignored start while busy.
    fm_src.delete(); g_src.delete();
    for (int i = 1; i <= 5; i++) fm_src.push_back(8'(8'hA0 + i));
    run_layer(12'h123, 12'h456, 1'b1, r, dc, fs, gs);
    check_int("t2_write_cycle", fm_last, r + 5);
    check_int("t2_done_cycle", dc, r + 6);

    // Two contested pairs: FM wins the first, guard the second.
    do_reset();
    fm_src.delete(); g_src.delete();
    for (int i = 0; i < 16; i++) fm_src.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) g_src.push_back(6'($urandom_range(0, 63)));
    run_layer(12'h080, 12'h0C0, 1'b0, r, dc, fs, gs);
    check_int("t3_fm_first", fm_first, r + 8);
    check_int("t3_guard_first", g_first, r + 9);
    check_int("t3_guard_wins_second", g_last, r + 16);
    check_int("t3_fm_last", fm_last, r + 17);
    check_int("t3_done_cycle", dc, r + 18);

    // Guard pending held by contention while the final guard word completes.
    do_reset();
    fm_src.delete(); g_src.delete();
    for (int i = 0; i < 8; i++) fm_src.push_back(8'(8'h10 + i));
    for (int i = 1; i <= 9; i++) g_src.push_back(6'(i));
    run_layer(12'h300, 12'h3F0, 1'b0, r, dc, fs, gs);
    check_int("t4_guard_stall_cycles", gs, 1);
    check_int("t4_fm_stalls", fs, 0);
    check_int("t4_guard_last", g_last, r + 10);
    check_int("t4_done_cycle", dc, r + 11);

    // FM address wraps past the top of the address space.
    fm_src.delete(); g_src.delete();
    for (int i = 0; i < 16; i++) fm_src.push_back(8'(8'hF0 - i));
    run_layer(12'hFFF, 12'h000, 1'b0, r, dc, fs, gs);
    check_int("t5_done_cycle", dc, r + 17);

    // Empty layer: done two cycles after start, no writes.
    fm_src.delete(); g_src.delete();
    nw = n_wr;
    run_layer(12'h555, 12'h666, 1'b0, r, dc, fs, gs);
    check_int("t6_done_cycle", dc, r + 1);
    check_int("t6_no_writes", n_wr - nw, 0);

    // Reset in the middle of a layer drops the held guard word.
    do_reset();
    fm_src.delete(); g_src.delete();
    for (int i = 0; i < 8; i++) fm_src.push_back(8'(8'h40 + i));
    for (int i = 0; i < 8; i++) g_src.push_back(6'(6'h20 + i));
    g_src.delete();
    push_expected(12'h040, 12'h300);
    for (int i = 0; i < 8; i++) g_src.push_back(6'(6'h20 + i));
    @(posedge clk); #1;
    bus.start_i      = 1'b1;
    bus.pace_i       = 16'd16;
    bus.guard_pace_i = 16'd16;
    bus.fm_base_i    = 12'h040;
    bus.guard_base_i = 12'h300;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.data_i_valid  = 1'b1;
      bus.data_i        = fm_src[i];
      bus.guard_i_valid = 1'b1;
      bus.guard_i       = g_src[i];
      @(posedge clk); #1;
    end
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_int("rst_mid_wr_en", int'(bus.mem_wr_en), 0);
    check_int("rst_mid_busy", int'(bus.busy_o), 0);
    check_int("rst_mid_done", int'(bus.done_o), 0);
    check_int("rst_mid_guard_ready", int'(bus.guard_buf_ready), 0);
    nw = n_wr;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_int("rst_mid_no_writes", n_wr - nw, 0);
    check_int("rst_mid_fm_word_written", exp_fm.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fm_guard_pack_writer.md
# fm_guard_pack_writer

Downstream stage of the feature-map/guard generator: consumes its 8-bit write-back byte stream and its 6-bit guard stream, packs each into 64-bit memory words, and writes them through one shared write port into the FM/guard buffer SRAM. One layer is processed per `start_i` pulse, after which `done_o` pulses.

## Interface
- `FM_WORD_BYTES`, 8: bytes per FM memory word.
- `GUARD_WORD_NUM`, 8: 6-bit guards per guard word.
- `ADDR_WIDTH`, 12: memory word-address width.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-high; port name is kept, polarity is high.
- `start_i`  in  1  layer start pulse; sampled only in IDLE.
- `pace_i`  in  16  FM bytes in the layer; latched at start.
- `guard_pace_i`  in  16  guard entries in the layer; latched at start.
- `fm_base_i`, `guard_base_i`  in  ADDR_WIDTH  first word address of each region; latched at start.
- `data_i`  in  8  write-back byte.
- `data_i_valid`  in  1  byte valid.
- `fm_buf_ready`  out  1  byte accepted when `data_i_valid && fm_buf_ready`.
- `guard_i`  in  6  guard entry.
- `guard_i_valid`  in  1  guard valid.
- `guard_buf_ready`  out  1  guard accepted when `guard_i_valid && guard_buf_ready`.
- `mem_wr_en`  out  1  write strobe; the SRAM always accepts.
- `mem_wr_sel`  out  1  0 = FM word, 1 = guard word.
- `mem_wr_addr`  out  ADDR_WIDTH  word address.
- `mem_wr_data`  out  64  word data.
- `busy_o`  out  1  high from start until done.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start_i`, latching pace, guard pace and both bases.
  - RUN→DONE when both of the following hold:
    - all `pace` bytes and `guard_pace` guards have been accepted;
    - both pending registers are empty.
  - DONE→IDLE unconditionally. `done_o` is high only in DONE.
- FM packing:
  - Accepted bytes fill lanes 0..7 of an accumulator; lane 0 is bits [7:0].
  - A word completes on lane 7 or on the layer's final byte. The final partial word is zero-padded in its upper lanes.
  - A completed word moves to the FM pending register `fm_pend_v`, and the lane counter resets.
- Guard packing: same scheme with 6-bit lanes (lane k = bits [6k+5:6k]). The 48-bit word is zero-extended to 64 bits.
- Ready rules:
  - `fm_buf_ready = RUN && fm_bytes_left!=0 && !(fm_pend_v && byte_would_complete_word)`.
  - The guard side uses the same rule.
  - Both readies are 0 outside RUN.
- Write arbitration:
  - One write per cycle.
  - If only one pending register is valid, it writes.
  - If both are valid, a 1-bit round-robin pointer decides. It resets to FM and flips after each contested grant.
  - A granted pending register clears in the same cycle, so a word completing that cycle may refill it.
- Addresses:
  - FM word n is written to `fm_base+n`; guard word n to `guard_base+n`.
  - Address arithmetic is modulo 2^ADDR_WIDTH and silently wraps.
- `pace_i==0` and `guard_pace_i==0`: RUN lasts one cycle, then DONE.
- `start_i` while not IDLE is ignored.
- Guard stream is independent of the byte stream; there is no ordering constraint between them.

## Timing
- Reset values:
  - all outputs 0;
  - FSM IDLE;
  - lane counters, pending valids and round-robin pointer cleared.
- Reset mid-layer discards all accumulated and pending data; no write follows reset.
- Byte accepted at cycle t completing a word → `fm_pend_v` at t+1 → `mem_wr_en` at t+1 if granted, else t+2.
- `mem_wr_*` is combinational from the pending registers and the arbiter; there is no extra register stage.
- `done_o` is asserted the cycle after the last memory write, or the cycle after the last acceptance if no write is pending.
- `busy_o` goes high the cycle after `start_i` and falls with `done_o`'s return to IDLE.
- Sustained throughput: 1 byte/cycle and 1 guard/cycle simultaneously, without stalls, since words complete at most once per 8 cycles per stream.

## Structure
- In `diff_core_pkg`:
  - `FM_WORD_BYTES`, `GUARD_WORD_NUM`, `FM_GUARD_MEM_ADDR_WIDTH`;
  - a typedef enum `pack_wr_state_e {PW_IDLE, PW_RUN, PW_DONE}`.
- Sub-module `lane_packer`:
  - parameters LANE_WIDTH and LANES;
  - contains the accumulator, lane counter, remaining count, pending register and ready logic;
  - instantiated twice (8×8 and 6×8).
- Top level contains the FSM, arbiter and address counters.

## Test plan
- pace=16, guard_pace=8, bases 0x010/0x200, bytes 0x00..0x0F and guards 0..7 streamed continuously:
  - FM writes 0x0706050403020100 @0x010 and 0x0F0E0D0C0B0A0908 @0x011;
  - guard word {6'd7,…,6'd0} zero-extended @0x200;
  - `done_o` 1 cycle after last write.
- pace=5, guard_pace=0, bytes 0xA1..0xA5 → single write 0x000000A5A4A3A2A1 @fm_base; done.
- Lane 7 byte and lane 7 guard accepted in the same cycle:
  - FM written at t+1, guard at t+2;
  - next contested pair grants guard first.
- Guard pending held by contention while the next guard word completes → `guard_buf_ready` low exactly 1 cycle, no data lost.
- fm_base=0xFFF, pace=16 → writes @0xFFF then @0x000.
- Reset and corner cases:
  - `rst_n` high mid-layer → outputs 0 next cycle, no further writes;
  - `start_i` while busy ignored;
  - pace=0 and guard_pace=0 → `done_o` 2 cycles after start.
